led_rate_sel: RTL and testbench

- Upstream control stage for the Go Board LED blinkers, clocked by the 25 MHz board clock.
- Debounces two push-buttons:
  - Switch 1 steps through four blink rates.
  - Switch 2 toggles pause/run.
- Emits a single-cycle toggle tick at the selected rate. Downstream LED logic inverts its LED on each tick instead of running its own free counters.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_rate_sel_switch_debounce.sv | 33 +++
 rtl/led_rate_sel.sv | 67 ++++++
 tb/tb_led_rate_sel.sv | 126 ++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared constants, rate encoding and rate state type for the Go Board LED blinkers.
package led_pkg;
  localparam int CLK_HZ         = 25000000;
  localparam int DEBOUNCE_LIMIT = 250000;
  localparam int LIMIT_0        = 12500000;
  localparam int LIMIT_1        = 6250000;
  localparam int LIMIT_2        = 2500000;
  localparam int LIMIT_3        = 1250000;
  localparam logic [1:0] RATE_1HZ  = 2'd0;
  localparam logic [1:0] RATE_2HZ  = 2'd1;
  localparam logic [1:0] RATE_5HZ  = 2'd2;
  localparam logic [1:0] RATE_10HZ = 2'd3;
  typedef enum logic [1:0] {
    R0 = RATE_1HZ,
    R1 = RATE_2HZ,
    R2 = RATE_5HZ,
    R3 = RATE_10HZ
  } rate_e;
endpackage

// File: rtl/led_rate_sel_switch_debounce.sv
// switch_debounce: accepts a raw switch level only after DEBOUNCE_LIMIT consecutive differing samples.
//   i_Clk    - system clock
//   i_Rst    - synchronous active-high reset
//   i_Switch - raw button level
//   o_Switch - debounced (stable) level
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = led_pkg::DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, diff, done;
  assign diff = i_Switch ^ stable_q;
  assign done = diff && (cnt_q == CW'(DEBOUNCE_LIMIT - 1));
  always_comb begin
    cnt_d    = (!diff || done) ? '0 : cnt_q + 1'b1;
    stable_d = done ? i_Switch : stable_q;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign o_Switch = stable_q;
endmodule

// File: rtl/led_rate_sel.sv
// led_rate_sel: debounced rate stepping and pause/run control producing a one-cycle toggle tick.
//   i_Clk      - 25 MHz system clock
//   i_Rst      - synchronous active-high reset
//   i_Switch_1 - raw button; release advances the rate
//   i_Switch_2 - raw button; release toggles run/pause
//   o_Rate_Sel - current rate index 0..3
//   o_Run      - 1 while ticking
//   o_Tick     - one-clock pulse every LIMIT_n clocks while running
module led_rate_sel
  import led_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = led_pkg::DEBOUNCE_LIMIT,
  parameter int LIMIT_0        = led_pkg::LIMIT_0,
  parameter int LIMIT_1        = led_pkg::LIMIT_1,
  parameter int LIMIT_2        = led_pkg::LIMIT_2,
  parameter int LIMIT_3        = led_pkg::LIMIT_3,
  parameter int CNT_W          = 24
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic [1:0] o_Rate_Sel,
  output logic       o_Run,
  output logic       o_Tick
);
  logic sw1_s, sw2_s, sw1_q, sw2_q, rel_1, rel_2, wrap, tick_q, tick_d, run_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  rate_e rate_q;
  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw1 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(i_Switch_1), .o_Switch(sw1_s)
  );
  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw2 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(i_Switch_2), .o_Switch(sw2_s)
  );
  assign rel_1 = sw1_q & ~sw1_s;
  assign rel_2 = sw2_q & ~sw2_s;
  always_comb begin
    lim    = (rate_q == R0) ? CNT_W'(LIMIT_0) :
             (rate_q == R1) ? CNT_W'(LIMIT_1) :
             (rate_q == R2) ? CNT_W'(LIMIT_2) : CNT_W'(LIMIT_3);
    wrap   = cnt_q == lim - 1'b1;
    // a rate change restarts the period and swallows any tick due on that edge
    cnt_d  = (rel_1 || !run_q || wrap) ? '0 : cnt_q + 1'b1;
    tick_d = !rel_1 && run_q && wrap;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sw1_q  <= 1'b0;
      sw2_q  <= 1'b0;
      rate_q <= R0;
      run_q  <= 1'b1;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      sw1_q  <= sw1_s;
      sw2_q  <= sw2_s;
      rate_q <= rel_1 ? rate_e'(rate_q + 2'd1) : rate_q;
      run_q  <= run_q ^ rel_2;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign o_Rate_Sel = rate_q;
  assign o_Run      = run_q;
  assign o_Tick     = tick_q;
endmodule

// File: tb/tb_led_rate_sel.sv
// tb_led_rate_sel: directed bench with small debounce and tick limits.
module tb_led_rate_sel;
  logic clk = 1'b0, rst = 1'b1, sw1 = 1'b0, sw2 = 1'b0;
  logic [1:0] rate;
  logic run, tick;
  int checks = 0, errors = 0;
  led_rate_sel #(
    .DEBOUNCE_LIMIT(4), .LIMIT_0(10), .LIMIT_1(6), .LIMIT_2(4), .LIMIT_3(2), .CNT_W(8)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_Rate_Sel(rate), .o_Run(run), .o_Tick(tick)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic gap(output int g);
    g = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (tick) begin
        g = i;
        break;
      end
    end
  endtask
  task automatic press(input logic s1, input logic s2);
    sw1 = s1;
    sw2 = s2;
    step(8);
    sw1 = 1'b0;
    sw2 = 1'b0;
    step(4);
  endtask
  initial begin
    int g, n, prev;
    int exp_r[5] = '{1, 2, 3, 0, 1};
    int exp_l[5] = '{6, 4, 2, 10, 6};
    step();
    chk("rst_rate", rate, 0);
    chk("rst_run", run, 1);
    chk("rst_tick", tick, 0);
    rst = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      step();
      chk($sformatf("boot_tick%0d", i), tick, (i % 10 == 0) ? 1 : 0);
    end
    chk("boot_rate", rate, 0);
    chk("boot_run", run, 1);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      press(1'b1, 1'b0);
      chk($sformatf("rate_hold%0d", k), rate, prev);
      step();
      chk($sformatf("rate_adv%0d", k), rate, exp_r[k]);
      chk($sformatf("rate_tick_supp%0d", k), tick, 0);
      gap(g);
      chk($sformatf("rate_gap_a%0d", k), g, exp_l[k]);
      gap(g);
      chk($sformatf("rate_gap_b%0d", k), g, exp_l[k]);
      prev = exp_r[k];
    end
    sw1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("glitch_tick", tick, 0);
    end
    sw1 = 1'b0;
    gap(g);
    chk("glitch_gap_a", g, 3);
    gap(g);
    chk("glitch_gap_b", g, 6);
    chk("glitch_rate", rate, 1);
    press(1'b0, 1'b1);
    chk("pause_hold", run, 1);
    step();
    chk("pause_run", run, 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      n += int'(tick);
    end
    chk("pause_ticks", n, 0);
    chk("pause_rate", rate, 1);
    press(1'b0, 1'b1);
    chk("resume_hold", run, 0);
    step();
    chk("resume_run", run, 1);
    gap(g);
    chk("resume_gap", g, 6);
    press(1'b1, 1'b1);
    chk("both_hold_rate", rate, 1);
    chk("both_hold_run", run, 1);
    step();
    chk("both_rate", rate, 2);
    chk("both_run", run, 0);
    chk("both_tick", tick, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      n += int'(tick);
    end
    chk("both_ticks", n, 0);
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rate", rate, 0);
    chk("mid_rst_run", run, 1);
    chk("mid_rst_tick", tick, 0);
    gap(g);
    chk("mid_rst_gap", g, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
